// File: rtl/duty_pkg.sv
// Shared types, default constants and the duty clamp helper for the duty_pwm block.
// The STOP state exists only when DUTY_SOFT_STOP_EN is defined.
package duty_pkg;

  localparam int unsigned DefaultPrescale = 8;
  localparam int unsigned DefaultSteps    = 10;

`ifdef DUTY_SOFT_STOP_EN
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStop
  } duty_state_e;
`else
  typedef enum logic [1:0] {
    StIdle,
    StRun
  } duty_state_e;
`endif

  function automatic logic [3:0] clamp_duty(input logic [3:0] duty, input logic [3:0] full);
    return (duty > full) ? full : duty;
  endfunction

endpackage

// File: rtl/pwm_tick.sv
// Prescaler: counts 0..PRESCALE-1 and flags the last count as a step tick.
// clr holds the count at zero.
module pwm_tick
  import duty_pkg::*;
#(
  parameter int unsigned PRESCALE = DefaultPrescale
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [7:0] LastCnt = 8'(PRESCALE - 1);

  logic [7:0] r_pre_cnt;

  assign tick = (r_pre_cnt == LastCnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre_cnt <= '0;
    end else if (clr || tick) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/duty_pwm.sv
// duty_pwm: prescaled PWM generator whose duty is latched once per period.
// Define DUTY_SOFT_STOP_EN to let a dropped en finish the current period via STOP.
module duty_pwm
  import duty_pkg::*;
#(
  parameter int unsigned PRESCALE = DefaultPrescale,
  parameter int unsigned STEPS    = DefaultSteps
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] duty_cycle,
  output logic       pwm_out,
  output logic       period_done,
  output logic       busy
);

  localparam logic [3:0] FullScale = 4'(STEPS);
  localparam logic [3:0] LastStep  = 4'(STEPS - 1);

  duty_state_e r_state, w_state_d;
  logic [3:0]  r_step, w_step_d;
  logic [3:0]  r_shadow, w_shadow_d;
  logic        r_pwm, w_pwm_d;
  logic        r_done, w_done_d;
  logic        w_tick, w_adv, w_wrap, w_clr;

  pwm_tick #(
    .PRESCALE(PRESCALE)
  ) u_pwm_tick (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .tick(w_tick)
  );

  assign w_adv  = w_tick && (r_state != StIdle);
  assign w_wrap = w_adv && (r_step == LastStep);
  // Prescaler sits at zero in IDLE so a new run always starts on a clean step.
  assign w_clr  = (r_state == StIdle) || (w_state_d == StIdle);

  always_comb begin
    w_state_d  = r_state;
    w_step_d   = r_step;
    w_shadow_d = r_shadow;

    if (w_adv) begin
      w_step_d = w_wrap ? 4'd0 : r_step + 4'd1;
      if (w_wrap) begin
        w_shadow_d = clamp_duty(duty_cycle, FullScale);
      end
    end

    case (r_state)
      StIdle: begin
        if (en) begin
          w_state_d  = StRun;
          w_step_d   = 4'd0;
          w_shadow_d = clamp_duty(duty_cycle, FullScale);
        end
      end
      StRun: begin
        if (!en) begin
`ifdef DUTY_SOFT_STOP_EN
          w_state_d = w_wrap ? StIdle : StStop;
`else
          w_state_d = StIdle;
`endif
        end
      end
`ifdef DUTY_SOFT_STOP_EN
      StStop: begin
        if (en) begin
          w_state_d = StRun;
        end else if (w_wrap) begin
          w_state_d = StIdle;
        end
      end
`endif
      default: w_state_d = StIdle;
    endcase

    if (w_state_d == StIdle) begin
      w_step_d = 4'd0;
    end

    w_done_d = w_wrap;
    // Output is decided from next-state values so it changes on the causing edge.
    w_pwm_d  = (w_state_d != StIdle) && (w_step_d < w_shadow_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_step   <= '0;
      r_shadow <= '0;
      r_pwm    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_step   <= w_step_d;
      r_shadow <= w_shadow_d;
      r_pwm    <= w_pwm_d;
      r_done   <= w_done_d;
    end
  end

  assign pwm_out     = r_pwm;
  assign period_done = r_done;
  assign busy        = (r_state != StIdle);

endmodule

// File: doc/duty_pwm.md
DUTY_PWM -- requirements
Module: duty_pwm

Interface
REQ-001 SHALL have parameter PRESCALE, default 8, clocks per PWM step (legal range 1..255).
REQ-002 SHALL have parameter STEPS, default 10, steps per PWM period and full-scale duty value (legal range 1..15).
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port en, input, 1, run request.
REQ-006 SHALL have port duty_cycle, input, 4, requested high steps per period.
REQ-007 SHALL have port pwm_out, output, 1, registered PWM drive.
REQ-008 SHALL have port period_done, output, 1, one-cycle pulse at each period wrap.
REQ-009 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, RUN and STOP; STOP exists only with the macro in REQ-024.
REQ-011 SHALL count pre_cnt 0..PRESCALE-1; tick is asserted when pre_cnt==PRESCALE-1, and pre_cnt then wraps to 0.
REQ-012 SHALL advance step_cnt 0..STEPS-1 on each tick and wrap to 0 after STEPS-1; period = STEPS*PRESCALE clocks.
REQ-013 SHALL load duty_shadow = min(duty_cycle, STEPS) on the IDLE->RUN edge and on every wrap edge (tick with step_cnt==STEPS-1).
REQ-014 SHALL ignore duty_cycle changes at all other times; a mid-period change affects the next period only.
REQ-015 SHALL drive pwm_out high for exactly duty_shadow*PRESCALE clocks starting at period start, then low for the rest of the period.
REQ-016 SHALL make pwm_out a flop: it updates on the same edge as the state/counter change that causes it, with no extra cycle of latency.
REQ-017 SHALL move IDLE->RUN on the first edge with en=1, clearing pre_cnt and step_cnt; pwm_out rises on that same edge if min(duty_cycle,STEPS)>0.
REQ-018 SHALL hold pwm_out at 0 for the whole period when duty_shadow=0, and at 1 for the whole period when duty_shadow=STEPS.
REQ-019 SHALL assert period_done for one clock on each wrap edge while in RUN or STOP, and never while in IDLE.
REQ-020 SHALL, without the macro, move RUN->IDLE on the first edge with en=0; that edge sets pwm_out=0 and clears the counters, and period_done stays low.
REQ-021 SHALL, when a wrap and en=0 coincide, take the wrap's period_done pulse and the exit on the same edge.

Reset
REQ-022 SHALL, while rst=1, immediately force state=IDLE, pre_cnt=0, step_cnt=0, duty_shadow=0, pwm_out=0, period_done=0 and busy=0.
REQ-023 SHALL, after rst is released, behave as cold IDLE; reset asserted mid-period discards the period with no period_done.

Configuration
REQ-024 SHALL have macro DUTY_SOFT_STOP_EN; when defined, en=0 in RUN moves the FSM to STOP instead of IDLE.
REQ-025 SHALL, in STOP, continue counting and PWM until the next wrap; at the wrap edge it pulses period_done, sets pwm_out=0 and enters IDLE.
REQ-026 SHALL, in STOP, return to RUN on en=1 without disturbing pre_cnt, step_cnt or duty_shadow.
REQ-027 SHALL, without DUTY_SOFT_STOP_EN, omit STOP entirely and behave as REQ-020.

Structure
REQ-028 SHALL take the state enum (IDLE/RUN/STOP) and the default PRESCALE/STEPS constants from shared package duty_pkg.
REQ-029 SHALL place the prescaler in sub-module pwm_tick (inputs clk, rst, clr; output tick); all other logic stays in duty_pwm.

Verification (PRESCALE=2, STEPS=10)
REQ-030 SHALL cover: en=1 with duty=4 -> pwm_out high 8 clocks, low 12 clocks, repeating; period_done every 20 clocks.
REQ-031 SHALL cover: duty=0 -> pwm_out stays 0; duty=10 -> pwm_out stays 1; duty=13 -> clamped, pwm_out stays 1; period_done still every 20 clocks in all three cases.
REQ-032 SHALL cover: duty changed 3->7 at step 5 -> current period gives 6 high clocks, next period gives 14 high clocks.
REQ-033 SHALL cover: en dropped at step 4 with duty=8, no macro -> next edge pwm_out=0, busy=0, no period_done.
REQ-034 SHALL cover: the same en drop with DUTY_SOFT_STOP_EN -> period completes (16 high clocks total), period_done pulses, then busy=0; en re-raised at step 7 keeps the waveform seamless.
REQ-035 SHALL cover: rst pulse mid-period -> all outputs are 0 immediately; with en held at 1, the first edge after release enters RUN and the new period starts at step 0.
